// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the wait-stated memory responder.
package mips_mem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a datapath initiator and the memory responder.
interface mem_responder_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM: write-enable plus registered read, contents never reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: FSM and request latches in front of mem_array, with WAIT_CYCLES wait states.
// Optional MEM_MISALIGN_CHECK_EN rejects non-word-aligned requests with resp_err.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_valid
// WAIT  | counting down wait states, request held in latches
// RESP  | response presented until resp_ready
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               go_resp;
  logic               write_q, err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               in_err;
  logic               acc_write, acc_err;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic               ram_en, ram_we;
  logic [DATA_W-1:0]  ram_rdata;
  logic               unused_addr_bits;

`ifdef MEM_MISALIGN_CHECK_EN
  assign in_err = (bus.req_addr[1:0] != 2'b00);
`else
  assign in_err = 1'b0;
`endif

  assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use the bus directly.
  assign acc_write = (state_q == IDLE) ? bus.req_write : write_q;
  assign acc_err   = (state_q == IDLE) ? in_err : err_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr[ADDR_W+1:2] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign ram_en    = go_resp && !reset;
  assign ram_we    = acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        err_q   <= in_err;
        addr_q  <= bus.req_addr[ADDR_W+1:2];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = (state_q == RESP && !write_q && !err_q) ? ram_rdata : '0;
`ifdef MEM_MISALIGN_CHECK_EN
  assign bus.resp_err   = (state_q == RESP) && err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule
